axi_burst_writer: RTL and testbench
===================================

# axi_burst_writer

Parametrised AXI4 write-burst master. It replaces the fixed single-burst master that sits behind the `s_axi_reg` control slave. On a start pulse it streams `LEN` words from the register bank as one or more AXI4 bursts of type FIXED, INCR or WRAP. It checks every write response and reports progress and errors through a status code that the control slave reads back.

## Interface
Parameters:
- `DATA_WIDTH`, 32: W data width; a power of two, at least 8.
- `ADDR_WIDTH`, 32: AW address width.
- `BRAM_QUANTITY`, 6: words in the source bank; this is the maximum beats per burst (limit 16).
- `ID_WIDTH`, 4: AXI ID width.
- `REPEAT_WIDTH`, 8: width of the burst-repeat count.

Ports:
- `clk` in 1: single clock; all logic rising-edge.
- `areset` in 1: asynchronous, active-low reset.
- `bram_i` in `[DATA_WIDTH-1:0]` x `BRAM_QUANTITY`: source words; beat k sends `bram_i[k]`.
- `start_i` in 1: start pulse; sampled only in IDLE.
- `base_addr_i` in ADDR_WIDTH: first burst address.
- `len_i` in 5: beats per burst, 1..16.
- `burst_i` in 2: 0 FIXED, 1 INCR, 2 WRAP, 3 reserved.
- `repeat_i` in REPEAT_WIDTH: bursts per run; 0 is treated as 1.
- `id_i` in ID_WIDTH: AWID/WID for the run.
- `awid_o`, `awaddr_o`, `awlen_o[7:0]`, `awsize_o[2:0]`, `awburst_o[1:0]`, `awvalid_o` out; `awready_i` in.
- `wid_o`, `wdata_o`, `wstrb_o`, `wlast_o`, `wvalid_o` out; `wready_i` in.
- `bid_i`, `bresp_i[1:0]`, `bvalid_i` in; `bready_o` out.
- `busy_o` out 1: high from start acceptance until return to IDLE.
- `done_o` out 1: one-cycle pulse on successful run completion.
- `status_o` out 3: code from `axi_bw_pkg`.
- `bursts_done_o` out REPEAT_WIDTH: bursts completed with OKAY in the current or last run.

## Operation
- FSM states: IDLE, ADDR, DATA, RESP, DONE, ERROR.
- IDLE with `start_i`=1: latch `base_addr_i`, `len_i`, `burst_i`, `repeat_i` and `id_i`. Then run the config check.
- Config check fails on any of the following; the FSM goes to ERROR with `STAT_CFG_ERR` and no AXI traffic:
  - `len_i`=0;
  - `len_i`>BRAM_QUANTITY;
  - `burst_i`=3;
  - WRAP with `len_i` not in {2,4,8,16};
  - `base_addr_i` not aligned to `DATA_WIDTH/8`;
  - an INCR burst crossing a 4 KB boundary. Check each burst's address at ADDR entry.
- If the check passes, go to ADDR.
- ADDR: `awvalid_o`=1 holding stable values:
  - `awlen_o`=len-1;
  - `awsize_o`=log2(DATA_WIDTH/8);
  - `awburst_o`=latched type.
  - On `awvalid_o`&`awready_i`, go to DATA with beat=0.
- DATA: `wvalid_o`=1, `wdata_o`=`bram_i[beat]` (sampled live), `wstrb_o`=all ones.
  - `wlast_o`=(beat==len-1).
  - Each handshake increments beat. The handshake on the last beat goes to RESP.
- RESP: `bready_o`=1 until `bvalid_i`.
  - `bresp_i`≠OKAY: go to ERROR with `STAT_RESP_ERR`.
  - `bid_i`≠latched id: go to ERROR with `STAT_ID_ERR`.
  - Otherwise increment `bursts_done_o`. If bursts remain, go to ADDR; else go to DONE.
- Next burst address: INCR adds len·DATA_WIDTH/8. FIXED and WRAP reuse the base address. Address arithmetic is modulo 2^ADDR_WIDTH.
- DONE: `done_o`=1 for one cycle, `status_o`=`STAT_OK`, then IDLE.
- ERROR: one cycle, then IDLE. The error status is held until the next accepted start.
- `start_i` outside IDLE is ignored.
- A new accepted start clears `bursts_done_o` and sets `status_o`=`STAT_BUSY`.

## Timing
- Reset values: all valid/ready/last outputs 0, `busy_o` 0, `done_o` 0, `status_o`=`STAT_IDLE`, counters 0, address/data outputs 0.
- Reset asserted mid-burst drops valids immediately and returns to IDLE.
- Start at edge n gives `awvalid_o` high from edge n+1.
- AW handshake at edge m gives `wvalid_o` from edge m+1.
- Zero-wait beats: one beat per cycle with no bubbles.
- Last W handshake at edge p gives `bready_o` from edge p+1.
- Response at edge q gives `awvalid_o` of the next burst at q+1, or `done_o` at q+1.
- Valid, once raised, holds with stable payload until handshake, independent of ready.
- `bvalid_i` arriving in the same cycle that `bready_o` rises is accepted.

## Structure
- Package `axi_bw_pkg` holds:
  - burst-type constants `BURST_FIXED`/`BURST_INCR`/`BURST_WRAP`;
  - status codes `STAT_IDLE`=0, `STAT_BUSY`=1, `STAT_OK`=2, `STAT_CFG_ERR`=3, `STAT_RESP_ERR`=4, `STAT_ID_ERR`=5;
  - the FSM state enum.
- One natural sub-module, `axi_bw_cfg_check`: combinational config validation plus the 4 KB-crossing test.

## Test plan
- INCR, base `0xA3DD0014`, len 4, repeat 2, all readies 1: AW addresses `0xA3DD0014` then `0xA3DD0024`, awlen 3, 8 beats = `bram_i[0..3]` twice, `wlast_o` on beats 3/7, `done_o` once, `bursts_done_o`=2.
- FIXED, len 1, repeat 3, `awready_i` delayed 3 cycles: AW payload stable while waiting, each AW address equals base, status `STAT_OK`.
- WRAP len 3: `STAT_CFG_ERR`, `awvalid_o` never asserted. WRAP len 4: accepted, `awburst_o`=2.
- INCR base `0x00000FF8`, len 4: 4 KB crossing gives `STAT_CFG_ERR`. Len 7 with BRAM_QUANTITY=6 also gives `STAT_CFG_ERR`.
- `bresp_i`=2 (SLVERR) on burst 1 of 2: `STAT_RESP_ERR`, no second AW, `bursts_done_o`=0. `bid_i`≠id gives `STAT_ID_ERR`.
- `areset` low during beat 2: all valids 0 that cycle, state IDLE. A new start afterwards completes normally.

Source files
------------

// File: rtl/axi_bw_pkg.sv
// Shared constants and types for the AXI4 write-burst master:
// burst encodings, status codes read back by the control slave, and FSM states.
package axi_bw_pkg;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    localparam logic [2:0] STAT_IDLE     = 3'd0;
    localparam logic [2:0] STAT_BUSY     = 3'd1;
    localparam logic [2:0] STAT_OK       = 3'd2;
    localparam logic [2:0] STAT_CFG_ERR  = 3'd3;
    localparam logic [2:0] STAT_RESP_ERR = 3'd4;
    localparam logic [2:0] STAT_ID_ERR   = 3'd5;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        RESP,
        DONE,
        ERROR
    } state_t;

endpackage

// File: rtl/axi_bw_if.sv
// AXI4 write-channel bundle (AW, W, B) between the burst master and its slave.
interface axi_bw_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]     awid_o;
    logic [ADDR_WIDTH-1:0]   awaddr_o;
    logic [7:0]              awlen_o;
    logic [2:0]              awsize_o;
    logic [1:0]              awburst_o;
    logic                    awvalid_o;
    logic                    awready_i;

    logic [ID_WIDTH-1:0]     wid_o;
    logic [DATA_WIDTH-1:0]   wdata_o;
    logic [DATA_WIDTH/8-1:0] wstrb_o;
    logic                    wlast_o;
    logic                    wvalid_o;
    logic                    wready_i;

    logic [ID_WIDTH-1:0]     bid_i;
    logic [1:0]              bresp_i;
    logic                    bvalid_i;
    logic                    bready_o;

    modport master (
        output awid_o, awaddr_o, awlen_o, awsize_o, awburst_o, awvalid_o,
        input  awready_i,
        output wid_o, wdata_o, wstrb_o, wlast_o, wvalid_o,
        input  wready_i,
        input  bid_i, bresp_i, bvalid_i,
        output bready_o
    );

    modport slave (
        input  awid_o, awaddr_o, awlen_o, awsize_o, awburst_o, awvalid_o,
        output awready_i,
        input  wid_o, wdata_o, wstrb_o, wlast_o, wvalid_o,
        output wready_i,
        output bid_i, bresp_i, bvalid_i,
        input  bready_o
    );
endinterface

// File: rtl/axi_bw_cfg_check.sv
// Combinational validation of a burst configuration: static length/type/alignment
// rules in cfg_err, and the INCR 4 KB page-crossing test in cross_err.
module axi_bw_cfg_check
    import axi_bw_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int BRAM_QUANTITY = 6
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [4:0]            len,
    input  logic [1:0]            burst,
    output logic                  cfg_err,
    output logic                  cross_err
);
    localparam int BYTES = DATA_WIDTH / 8;

    logic        len_bad;
    logic        burst_bad;
    logic        wrap_bad;
    logic        align_bad;
    logic [12:0] end_off;

    always_comb begin
        len_bad   = (len == 5'd0) || (int'(len) > BRAM_QUANTITY);
        burst_bad = (burst == 2'd3);
        wrap_bad  = (burst == BURST_WRAP) && !(len inside {5'd2, 5'd4, 5'd8, 5'd16});
        align_bad = (addr & ADDR_WIDTH'(BYTES - 1)) != '0;
        // A burst ending exactly on the page boundary is still legal.
        end_off   = {1'b0, addr[11:0]} + 13'(int'(len) * BYTES);
        cross_err = (burst == BURST_INCR) && (end_off > 13'd4096);
        cfg_err   = len_bad || burst_bad || wrap_bad || align_bad;
    end

endmodule

// File: rtl/axi_burst_writer.sv
// AXI4 write-burst master: streams len words from the register bank as repeated
// FIXED/INCR/WRAP bursts, checks every B response and reports a status code.
module axi_burst_writer
    import axi_bw_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int BRAM_QUANTITY = 6,
    parameter int ID_WIDTH      = 4,
    parameter int REPEAT_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    areset,
    input  logic [DATA_WIDTH-1:0]   bram_i [BRAM_QUANTITY],
    input  logic                    start_i,
    input  logic [ADDR_WIDTH-1:0]   base_addr_i,
    input  logic [4:0]              len_i,
    input  logic [1:0]              burst_i,
    input  logic [REPEAT_WIDTH-1:0] repeat_i,
    input  logic [ID_WIDTH-1:0]     id_i,
    axi_bw_if.master                axi,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [2:0]              status_o,
    output logic [REPEAT_WIDTH-1:0] bursts_done_o
);
    localparam int         BYTES  = DATA_WIDTH / 8;
    localparam logic [2:0] AWSIZE = 3'($clog2(BYTES));

    state_t                  state, state_nxt;
    logic [3:0]              beat, beat_nxt;
    logic [REPEAT_WIDTH-1:0] done_cnt, done_cnt_nxt, done_inc;
    logic [2:0]              status, status_nxt;

    logic [ADDR_WIDTH-1:0]   addr, next_addr;
    logic [4:0]              len;
    logic [1:0]              burst;
    logic [REPEAT_WIDTH-1:0] rep;
    logic [ID_WIDTH-1:0]     id;

    logic [ADDR_WIDTH-1:0]   chk_addr;
    logic [4:0]              chk_len;
    logic [1:0]              chk_burst;
    logic                    cfg_err, cross_err;
    logic                    last_beat;
    logic [DATA_WIDTH-1:0]   wsel;

    // In IDLE the checker sees the incoming request, otherwise the next burst.
    assign next_addr = (burst == BURST_INCR) ? addr + ADDR_WIDTH'(int'(len) * BYTES) : addr;
    assign chk_addr  = (state == IDLE) ? base_addr_i : next_addr;
    assign chk_len   = (state == IDLE) ? len_i : len;
    assign chk_burst = (state == IDLE) ? burst_i : burst;
    assign last_beat = ({1'b0, beat} == len - 5'd1);
    assign done_inc  = done_cnt + REPEAT_WIDTH'(1);

    axi_bw_cfg_check #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDR_WIDTH    (ADDR_WIDTH),
        .BRAM_QUANTITY (BRAM_QUANTITY)
    ) u_cfg_check (
        .addr      (chk_addr),
        .len       (chk_len),
        .burst     (chk_burst),
        .cfg_err   (cfg_err),
        .cross_err (cross_err)
    );

    always_comb begin
        wsel = '0;
        for (int k = 0; k < BRAM_QUANTITY; k++) begin
            if (beat == 4'(k)) wsel = bram_i[k];
        end
    end

    always_comb begin
        state_nxt    = state;
        beat_nxt     = beat;
        done_cnt_nxt = done_cnt;
        status_nxt   = status;
        case (state)
            IDLE: if (start_i) begin
                done_cnt_nxt = '0;
                if (cfg_err || cross_err) begin
                    state_nxt  = ERROR;
                    status_nxt = STAT_CFG_ERR;
                end else begin
                    state_nxt  = ADDR;
                    status_nxt = STAT_BUSY;
                end
            end
            ADDR: if (axi.awready_i) begin
                state_nxt = DATA;
                beat_nxt  = '0;
            end
            DATA: if (axi.wready_i) begin
                beat_nxt = beat + 4'd1;
                if (last_beat) state_nxt = RESP;
            end
            RESP: if (axi.bvalid_i) begin
                if (axi.bresp_i != 2'b00) begin
                    state_nxt  = ERROR;
                    status_nxt = STAT_RESP_ERR;
                end else if (axi.bid_i != id) begin
                    state_nxt  = ERROR;
                    status_nxt = STAT_ID_ERR;
                end else begin
                    done_cnt_nxt = done_inc;
                    if (done_inc == rep) begin
                        state_nxt  = DONE;
                        status_nxt = STAT_OK;
                    end else if (cfg_err || cross_err) begin
                        state_nxt  = ERROR;
                        status_nxt = STAT_CFG_ERR;
                    end else begin
                        state_nxt  = ADDR;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            ERROR:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state    <= IDLE;
            beat     <= '0;
            done_cnt <= '0;
            status   <= STAT_IDLE;
        end else begin
            state    <= state_nxt;
            beat     <= beat_nxt;
            done_cnt <= done_cnt_nxt;
            status   <= status_nxt;
        end
    end

    // Run configuration; outputs are gated by the valids so these need no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && start_i) begin
            addr  <= base_addr_i;
            len   <= len_i;
            burst <= burst_i;
            rep   <= (repeat_i == '0) ? REPEAT_WIDTH'(1) : repeat_i;
            id    <= id_i;
        end else if (state == RESP && state_nxt == ADDR) begin
            addr  <= next_addr;
        end
    end

    always_comb begin
        axi.awvalid_o = (state == ADDR);
        axi.awaddr_o  = axi.awvalid_o ? addr : '0;
        axi.awlen_o   = axi.awvalid_o ? {3'b000, len - 5'd1} : '0;
        axi.awsize_o  = axi.awvalid_o ? AWSIZE : '0;
        axi.awburst_o = axi.awvalid_o ? burst : '0;
        axi.awid_o    = axi.awvalid_o ? id : '0;
        axi.wvalid_o  = (state == DATA);
        axi.wdata_o   = axi.wvalid_o ? wsel : '0;
        axi.wstrb_o   = axi.wvalid_o ? '1 : '0;
        axi.wlast_o   = axi.wvalid_o && last_beat;
        axi.wid_o     = axi.wvalid_o ? id : '0;
        axi.bready_o  = (state == RESP);
        busy_o        = (state != IDLE);
        done_o        = (state == DONE);
        status_o      = status;
        bursts_done_o = done_cnt;
    end

endmodule

// File: tb/tb_axi_burst_writer.sv
// Directed bench for axi_burst_writer: a simple AXI write slave, a channel monitor,
// and one task per scenario with hand-computed expectations.
module tb_axi_burst_writer;
    import axi_bw_pkg::*;

    localparam int DW = 32, AW = 32, BQ = 6, IW = 4, RW = 8;

    logic          clk = 1'b0;
    logic          areset;
    logic [DW-1:0] bram [BQ];
    logic          start;
    logic [AW-1:0] base_addr;
    logic [4:0]    len;
    logic [1:0]    burst;
    logic [RW-1:0] rep;
    logic [IW-1:0] id;
    logic          busy, done;
    logic [2:0]    status;
    logic [RW-1:0] bursts_done;

    int n_cmp  = 0;
    int n_fail = 0;

    axi_bw_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) axi ();

    axi_burst_writer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BRAM_QUANTITY(BQ), .ID_WIDTH(IW), .REPEAT_WIDTH(RW)
    ) dut (
        .clk           (clk),
        .areset        (areset),
        .bram_i        (bram),
        .start_i       (start),
        .base_addr_i   (base_addr),
        .len_i         (len),
        .burst_i       (burst),
        .repeat_i      (rep),
        .id_i          (id),
        .axi           (axi),
        .busy_o        (busy),
        .done_o        (done),
        .status_o      (status),
        .bursts_done_o (bursts_done)
    );

    always #5 clk = ~clk;

    // Slave model: configurable AW delay, B answered as soon as bready rises.
    int            aw_delay  = 0;
    int            aw_wait   = 0;
    int            err_burst = -1;
    int            b_base    = 0;
    int            b_cnt     = 0;
    logic [IW-1:0] bid_val   = '0;

    always @(negedge clk) begin
        if (axi.awvalid_o) begin
            axi.awready_i = (aw_wait >= aw_delay);
            aw_wait       = aw_wait + 1;
        end else begin
            axi.awready_i = 1'b0;
            aw_wait       = 0;
        end
        axi.wready_i = 1'b1;
        axi.bvalid_i = axi.bready_o;
        axi.bid_i    = bid_val;
        axi.bresp_i  = ((b_cnt - b_base) == err_burst) ? 2'b10 : 2'b00;
    end

    // Channel monitor.
    logic [AW-1:0]   aw_addr_q [$];
    logic [7:0]      aw_len_q [$];
    logic [2:0]      aw_size_q [$];
    logic [1:0]      aw_burst_q [$];
    logic [IW-1:0]   aw_id_q [$];
    logic [DW-1:0]   w_data_q [$];
    logic            w_last_q [$];
    logic [DW/8-1:0] w_strb_q [$];
    int              w_cyc_q [$];
    int              cyc = 0, done_cnt = 0, awv_cycles = 0, aw_unstable = 0;
    logic            aw_hold = 1'b0;
    logic [AW+8+2+IW-1:0] aw_saved = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (aw_hold && axi.awvalid_o &&
            {axi.awaddr_o, axi.awlen_o, axi.awburst_o, axi.awid_o} !== aw_saved)
            aw_unstable <= aw_unstable + 1;
        aw_hold  <= axi.awvalid_o && !axi.awready_i;
        aw_saved <= {axi.awaddr_o, axi.awlen_o, axi.awburst_o, axi.awid_o};
        if (axi.awvalid_o) awv_cycles <= awv_cycles + 1;
        if (axi.awvalid_o && axi.awready_i) begin
            aw_addr_q.push_back(axi.awaddr_o);
            aw_len_q.push_back(axi.awlen_o);
            aw_size_q.push_back(axi.awsize_o);
            aw_burst_q.push_back(axi.awburst_o);
            aw_id_q.push_back(axi.awid_o);
        end
        if (axi.wvalid_o && axi.wready_i) begin
            w_data_q.push_back(axi.wdata_o);
            w_last_q.push_back(axi.wlast_o);
            w_strb_q.push_back(axi.wstrb_o);
            w_cyc_q.push_back(cyc);
        end
        if (axi.bvalid_i && axi.bready_o) b_cnt <= b_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic run(input logic [AW-1:0] a, input logic [4:0] l, input logic [1:0] b,
                       input logic [RW-1:0] r, input logic [IW-1:0] i, input logic [IW-1:0] bi,
                       output logic first_awv, output logic [2:0] first_stat);
        logic timed_out;
        @(negedge clk);
        base_addr = a; len = l; burst = b; rep = r; id = i; bid_val = bi;
        b_base = b_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        first_awv  = axi.awvalid_o;
        first_stat = status;
        timed_out  = 1'b1;
        for (int k = 0; k < 400; k++) begin
            if (!busy) begin timed_out = 1'b0; break; end
            @(negedge clk);
        end
        n_cmp++;
        if (timed_out) begin n_fail++; $display("FAIL run_timeout busy=%b required=0", busy); end
    endtask

    task automatic test_reset();
        areset = 1'b0; start = 1'b0; base_addr = '0; len = '0; burst = '0; rep = '0; id = '0;
        for (int k = 0; k < BQ; k++) bram[k] = 32'hC0DE_0000 + DW'(k);
        repeat (3) @(negedge clk);
        n_cmp++; if (axi.awvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_awvalid got=%b exp=0", axi.awvalid_o); end
        n_cmp++; if (axi.wvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_wvalid got=%b exp=0", axi.wvalid_o); end
        n_cmp++; if (axi.wlast_o !== 1'b0) begin n_fail++; $display("FAIL reset_wlast got=%b exp=0", axi.wlast_o); end
        n_cmp++; if (axi.bready_o !== 1'b0) begin n_fail++; $display("FAIL reset_bready got=%b exp=0", axi.bready_o); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_cmp++; if (status !== STAT_IDLE) begin n_fail++; $display("FAIL reset_status got=%0d exp=%0d", status, STAT_IDLE); end
        n_cmp++; if (bursts_done !== '0) begin n_fail++; $display("FAIL reset_bursts_done got=%0d exp=0", bursts_done); end
        n_cmp++; if (axi.awaddr_o !== '0) begin n_fail++; $display("FAIL reset_awaddr got=%h exp=0", axi.awaddr_o); end
        n_cmp++; if (axi.wdata_o !== '0) begin n_fail++; $display("FAIL reset_wdata got=%h exp=0", axi.wdata_o); end
        areset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_incr();
        int qa, qw, d0;
        logic fa; logic [2:0] fs;
        qa = aw_addr_q.size(); qw = w_data_q.size(); d0 = done_cnt;
        run(32'hA3DD_0014, 5'd4, BURST_INCR, 8'd2, 4'd5, 4'd5, fa, fs);
        n_cmp++; if (fa !== 1'b1) begin n_fail++; $display("FAIL incr_awvalid_latency got=%b exp=1", fa); end
        n_cmp++; if (fs !== STAT_BUSY) begin n_fail++; $display("FAIL incr_status_busy got=%0d exp=%0d", fs, STAT_BUSY); end
        n_cmp++; if (aw_addr_q.size() !== qa + 2) begin n_fail++; $display("FAIL incr_aw_count got=%0d exp=%0d", aw_addr_q.size() - qa, 2); end
        n_cmp++; if (w_data_q.size() !== qw + 8) begin n_fail++; $display("FAIL incr_w_count got=%0d exp=8", w_data_q.size() - qw); end
        if (aw_addr_q.size() >= qa + 2) begin
            n_cmp++; if (aw_addr_q[qa] !== 32'hA3DD_0014) begin n_fail++; $display("FAIL incr_addr0 got=%h exp=a3dd0014", aw_addr_q[qa]); end
            n_cmp++; if (aw_addr_q[qa+1] !== 32'hA3DD_0024) begin n_fail++; $display("FAIL incr_addr1 got=%h exp=a3dd0024", aw_addr_q[qa+1]); end
            n_cmp++; if (aw_len_q[qa] !== 8'd3 || aw_len_q[qa+1] !== 8'd3) begin n_fail++; $display("FAIL incr_awlen got=%0d/%0d exp=3/3", aw_len_q[qa], aw_len_q[qa+1]); end
            n_cmp++; if (aw_size_q[qa] !== 3'd2) begin n_fail++; $display("FAIL incr_awsize got=%0d exp=2", aw_size_q[qa]); end
            n_cmp++; if (aw_burst_q[qa] !== BURST_INCR) begin n_fail++; $display("FAIL incr_awburst got=%0d exp=1", aw_burst_q[qa]); end
            n_cmp++; if (aw_id_q[qa+1] !== 4'd5) begin n_fail++; $display("FAIL incr_awid got=%0d exp=5", aw_id_q[qa+1]); end
        end
        if (w_data_q.size() >= qw + 8) begin
            for (int i = 0; i < 8; i++) begin
                n_cmp++;
                if (w_data_q[qw+i] !== bram[i%4] || w_last_q[qw+i] !== (i % 4 == 3)) begin
                    n_fail++;
                    $display("FAIL incr_beat%0d got=%h last=%b exp=%h last=%b", i, w_data_q[qw+i], w_last_q[qw+i], bram[i%4], (i % 4 == 3));
                end
            end
            for (int i = 1; i < 4; i++) begin
                n_cmp++; if (w_cyc_q[qw+i] - w_cyc_q[qw+i-1] !== 1) begin n_fail++; $display("FAIL incr_no_bubble beat%0d gap=%0d exp=1", i, w_cyc_q[qw+i] - w_cyc_q[qw+i-1]); end
            end
            n_cmp++; if (w_strb_q[qw] !== 4'hF) begin n_fail++; $display("FAIL incr_wstrb got=%h exp=f", w_strb_q[qw]); end
        end
        n_cmp++; if (done_cnt !== d0 + 1) begin n_fail++; $display("FAIL incr_done_pulses got=%0d exp=1", done_cnt - d0); end
        n_cmp++; if (bursts_done !== 8'd2) begin n_fail++; $display("FAIL incr_bursts_done got=%0d exp=2", bursts_done); end
        n_cmp++; if (status !== STAT_OK) begin n_fail++; $display("FAIL incr_status got=%0d exp=%0d", status, STAT_OK); end
    endtask

    task automatic test_fixed_delay();
        int qa, qw, u0, v0;
        logic fa; logic [2:0] fs;
        qa = aw_addr_q.size(); qw = w_data_q.size(); u0 = aw_unstable; v0 = awv_cycles;
        aw_delay = 3;
        run(32'h0000_0100, 5'd1, BURST_FIXED, 8'd3, 4'd2, 4'd2, fa, fs);
        aw_delay = 0;
        n_cmp++; if (aw_addr_q.size() !== qa + 3) begin n_fail++; $display("FAIL fixed_aw_count got=%0d exp=3", aw_addr_q.size() - qa); end
        if (aw_addr_q.size() >= qa + 3) begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++; if (aw_addr_q[qa+i] !== 32'h100 || aw_burst_q[qa+i] !== BURST_FIXED) begin n_fail++; $display("FAIL fixed_addr%0d got=%h/%0d exp=100/0", i, aw_addr_q[qa+i], aw_burst_q[qa+i]); end
            end
        end
        n_cmp++; if (awv_cycles - v0 !== 12) begin n_fail++; $display("FAIL fixed_awvalid_cycles got=%0d exp=12", awv_cycles - v0); end
        n_cmp++; if (aw_unstable !== u0) begin n_fail++; $display("FAIL fixed_aw_stable changes=%0d exp=0", aw_unstable - u0); end
        n_cmp++; if (w_data_q.size() !== qw + 3) begin n_fail++; $display("FAIL fixed_w_count got=%0d exp=3", w_data_q.size() - qw); end
        else begin
            n_cmp++; if (w_data_q[qw+2] !== bram[0] || w_last_q[qw+2] !== 1'b1) begin n_fail++; $display("FAIL fixed_beat got=%h/%b exp=%h/1", w_data_q[qw+2], w_last_q[qw+2], bram[0]); end
        end
        n_cmp++; if (status !== STAT_OK) begin n_fail++; $display("FAIL fixed_status got=%0d exp=%0d", status, STAT_OK); end
        n_cmp++; if (bursts_done !== 8'd3) begin n_fail++; $display("FAIL fixed_bursts_done got=%0d exp=3", bursts_done); end
    endtask

    task automatic test_wrap();
        int qa, v0;
        logic fa; logic [2:0] fs;
        qa = aw_addr_q.size(); v0 = awv_cycles;
        run(32'h0000_0200, 5'd3, BURST_WRAP, 8'd1, 4'd1, 4'd1, fa, fs);
        n_cmp++; if (fs !== STAT_CFG_ERR) begin n_fail++; $display("FAIL wrap3_first_status got=%0d exp=%0d", fs, STAT_CFG_ERR); end
        n_cmp++; if (awv_cycles !== v0) begin n_fail++; $display("FAIL wrap3_awvalid cycles=%0d exp=0", awv_cycles - v0); end
        n_cmp++; if (bursts_done !== '0) begin n_fail++; $display("FAIL wrap3_bursts_done got=%0d exp=0", bursts_done); end
        repeat (3) @(negedge clk);
        n_cmp++; if (status !== STAT_CFG_ERR) begin n_fail++; $display("FAIL wrap3_status_held got=%0d exp=%0d", status, STAT_CFG_ERR); end
        run(32'h0000_0200, 5'd4, BURST_WRAP, 8'd1, 4'd1, 4'd1, fa, fs);
        n_cmp++; if (status !== STAT_OK) begin n_fail++; $display("FAIL wrap4_status got=%0d exp=%0d", status, STAT_OK); end
        n_cmp++; if (aw_addr_q.size() !== qa + 1) begin n_fail++; $display("FAIL wrap4_aw_count got=%0d exp=1", aw_addr_q.size() - qa); end
        else begin
            n_cmp++; if (aw_burst_q[qa] !== 2'd2 || aw_len_q[qa] !== 8'd3 || aw_addr_q[qa] !== 32'h200) begin n_fail++; $display("FAIL wrap4_aw got=%0d/%0d/%h exp=2/3/200", aw_burst_q[qa], aw_len_q[qa], aw_addr_q[qa]); end
        end
    endtask

    task automatic test_cfg_errors();
        logic [AW-1:0] ta [6];
        logic [4:0]    tl [6];
        logic [1:0]    tb [6];
        logic [2:0]    te [6];
        int qa;
        logic fa; logic [2:0] fs;
        ta = '{32'hFF8, 32'h100, 32'h100, 32'h100, 32'h102, 32'hFF0};
        tl = '{5'd4, 5'd7, 5'd0, 5'd2, 5'd2, 5'd4};
        tb = '{BURST_INCR, BURST_INCR, BURST_INCR, 2'd3, BURST_INCR, BURST_INCR};
        te = '{STAT_CFG_ERR, STAT_CFG_ERR, STAT_CFG_ERR, STAT_CFG_ERR, STAT_CFG_ERR, STAT_OK};
        for (int i = 0; i < 6; i++) begin
            qa = aw_addr_q.size();
            run(ta[i], tl[i], tb[i], 8'd1, 4'd4, 4'd4, fa, fs);
            n_cmp++; if (status !== te[i]) begin n_fail++; $display("FAIL cfg%0d_status got=%0d exp=%0d", i, status, te[i]); end
            n_cmp++; if (aw_addr_q.size() - qa !== ((te[i] == STAT_OK) ? 1 : 0)) begin n_fail++; $display("FAIL cfg%0d_aw_count got=%0d", i, aw_addr_q.size() - qa); end
        end
    endtask

    task automatic test_resp_errors();
        int qa, d0;
        logic fa; logic [2:0] fs;
        qa = aw_addr_q.size(); d0 = done_cnt;
        err_burst = 0;
        run(32'h0000_0300, 5'd2, BURST_INCR, 8'd2, 4'd3, 4'd3, fa, fs);
        err_burst = -1;
        n_cmp++; if (status !== STAT_RESP_ERR) begin n_fail++; $display("FAIL resp_status got=%0d exp=%0d", status, STAT_RESP_ERR); end
        n_cmp++; if (aw_addr_q.size() !== qa + 1) begin n_fail++; $display("FAIL resp_aw_count got=%0d exp=1", aw_addr_q.size() - qa); end
        n_cmp++; if (bursts_done !== '0) begin n_fail++; $display("FAIL resp_bursts_done got=%0d exp=0", bursts_done); end
        n_cmp++; if (done_cnt !== d0) begin n_fail++; $display("FAIL resp_done_pulses got=%0d exp=0", done_cnt - d0); end
        run(32'h0000_0300, 5'd2, BURST_INCR, 8'd1, 4'd3, 4'd9, fa, fs);
        n_cmp++; if (status !== STAT_ID_ERR) begin n_fail++; $display("FAIL id_status got=%0d exp=%0d", status, STAT_ID_ERR); end
        n_cmp++; if (bursts_done !== '0) begin n_fail++; $display("FAIL id_bursts_done got=%0d exp=0", bursts_done); end
        qa = aw_addr_q.size();
        run(32'h0000_0500, 5'd1, BURST_INCR, 8'd0, 4'd3, 4'd3, fa, fs);
        n_cmp++; if (status !== STAT_OK || bursts_done !== 8'd1) begin n_fail++; $display("FAIL rep0_result got=%0d/%0d exp=%0d/1", status, bursts_done, STAT_OK); end
        n_cmp++; if (aw_addr_q.size() !== qa + 1) begin n_fail++; $display("FAIL rep0_aw_count got=%0d exp=1", aw_addr_q.size() - qa); end
    endtask

    task automatic test_reset_mid_burst();
        int qa, qw, d0;
        logic reached;
        logic fa; logic [2:0] fs;
        qw = w_data_q.size();
        @(negedge clk);
        base_addr = 32'h400; len = 5'd6; burst = BURST_INCR; rep = 8'd1; id = 4'd6; bid_val = 4'd6;
        b_base = b_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reached = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (w_data_q.size() >= qw + 2) begin reached = 1'b1; break; end
            @(negedge clk);
        end
        n_cmp++; if (reached !== 1'b1) begin n_fail++; $display("FAIL rst_mid_reach beats=%0d exp=2", w_data_q.size() - qw); end
        n_cmp++; if (axi.wvalid_o !== 1'b1 || axi.wdata_o !== bram[2]) begin n_fail++; $display("FAIL rst_mid_beat2 got=%b/%h exp=1/%h", axi.wvalid_o, axi.wdata_o, bram[2]); end
        #1 areset = 1'b0;
        #1;
        n_cmp++; if (axi.wvalid_o !== 1'b0 || axi.awvalid_o !== 1'b0 || axi.bready_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valids got=%b%b%b exp=000", axi.awvalid_o, axi.wvalid_o, axi.bready_o); end
        n_cmp++; if (busy !== 1'b0 || status !== STAT_IDLE) begin n_fail++; $display("FAIL rst_mid_idle busy=%b status=%0d exp=0/0", busy, status); end
        @(negedge clk);
        areset = 1'b1;
        qa = aw_addr_q.size(); d0 = done_cnt;
        run(32'h0000_0040, 5'd2, BURST_INCR, 8'd1, 4'd7, 4'd7, fa, fs);
        n_cmp++; if (status !== STAT_OK || bursts_done !== 8'd1) begin n_fail++; $display("FAIL rst_after_run got=%0d/%0d exp=%0d/1", status, bursts_done, STAT_OK); end
        n_cmp++; if (done_cnt !== d0 + 1) begin n_fail++; $display("FAIL rst_after_done got=%0d exp=1", done_cnt - d0); end
        n_cmp++; if (aw_addr_q.size() !== qa + 1) begin n_fail++; $display("FAIL rst_after_aw_count got=%0d exp=1", aw_addr_q.size() - qa); end
        else begin
            n_cmp++; if (aw_addr_q[qa] !== 32'h40) begin n_fail++; $display("FAIL rst_after_addr got=%h exp=40", aw_addr_q[qa]); end
        end
    endtask

    initial begin
        test_reset();
        test_incr();
        test_fixed_delay();
        test_wrap();
        test_cfg_errors();
        test_resp_errors();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
